tile_psum_drain: RTL
====================

// Module: tile_psum_drain
// PURPOSE
//  Downstream stage of the tile array: captures one row of per-lane partial sums per beat,
//  accumulates them over K passes into wide per-lane accumulators, then requantizes
//  (round, shift, narrow) and drains the lanes one at a time over a valid/ready stream to
//  the output/feature-map writer. Decouples the array's fixed cadence from writer back-pressure.
// PARAMETERS
//  AK_BW   20  width of one signed partial sum from the tile array
//  LANES   25  lanes per beat (COLS*T_COLS)
//  ACC_BW  24  signed accumulator width per lane (AK_BW + 4 guard bits)
//  O_BW    8   signed output element width
//  SH_BW   5   width of requant shift amount
// PORTS
//  clk          in   1                   clock, all logic on rising edge
//  rst          in   1                   synchronous reset, active-high
//  i_psum_vld   in   1                   partial-sum beat valid
//  i_psum_first in   1                   beat is first pass of a K-sequence (qualified by vld)
//  i_psum_last  in   1                   beat is last pass of a K-sequence (qualified by vld)
//  i_psum       in   AK_BW*LANES         signed partial sums, lane n at [(n+1)*AK_BW-1 -: AK_BW]
//  i_shift      in   SH_BW               requant right-shift, sampled on the last beat
//  o_busy       out  1                   high in DRAIN; upstream must hold new beats
//  o_drop       out  1                   1-cycle pulse: a valid beat was discarded
//  o_vld        out  1                   output element valid
//  i_rdy        in   1                   downstream ready
//  o_data       out  O_BW                requantized signed element
//  o_lane       out  $clog2(LANES)       lane index of o_data
//  o_last       out  1                   high with the final lane (LANES-1)
// BEHAVIOUR
//  - Reset: state=IDLE, all acc=0, lane cnt=0, shift reg=0; o_busy,o_drop,o_vld,o_last=0,
//    o_data=0, o_lane=0. Reset mid-DRAIN abandons the drain; no further o_vld.
//  - FSM IDLE/ACCUM/DRAIN:
//    IDLE : vld&first -> acc[n]=sext(psum[n]); last also high -> DRAIN, else -> ACCUM.
//           vld&!first -> beat discarded, o_drop pulses next cycle.
//    ACCUM: vld&first -> reload acc (restart sequence). vld&!first -> acc[n]+=sext(psum[n]).
//           vld&last -> latch i_shift, -> DRAIN next cycle (this beat is accumulated).
//    DRAIN: o_vld=1, o_lane=cnt, o_data=requant(acc[cnt]); advance cnt on o_vld&i_rdy.
//           Handshake at cnt==LANES-1 (o_last=1) -> IDLE, cnt=0. Any vld in DRAIN
//           discarded, o_drop pulses. o_data/o_lane/o_last stable while o_vld&!i_rdy.
//  - Latency: last beat at cycle t -> first o_vld at t+1; zero back-pressure drain takes
//    LANES cycles; next beat accepted the cycle after the final handshake (o_busy low).
//  - Arithmetic: accumulation two's-complement, wraps modulo 2^ACC_BW (no detection).
//    requant: if sh>0, v=(acc + (1<<(sh-1))) >>> sh (round half up), else v=acc;
//    v computed at ACC_BW+1 bits so rounding add cannot wrap.
//  - o_drop is registered (pulse one cycle after the discarded beat); not sticky.
// CONFIGURATION
//  PSUM_DRAIN_SAT_EN defined : o_data = clamp(v, -2^(O_BW-1), 2^(O_BW-1)-1).
//  PSUM_DRAIN_SAT_EN undefined: o_data = v[O_BW-1:0] (truncation, wraps).
// STRUCTURE
//  - tile_pkg: state enum typedef (IDLE/ACCUM/DRAIN), default width constants
//    (AK_BW, ACC_BW, O_BW, SH_BW), lane-slice helper function.
//  - Sub-module psum_requant: combinational round/shift/narrow (+ saturation under
//    PSUM_DRAIN_SAT_EN) on one ACC_BW value; single instance on the drain mux output.
//  - Accumulator array, lane counter and FSM live in tile_psum_drain.
// TESTING
//  1 Single pass: vld,first,last, all lanes psum=100, shift=2, i_rdy=1 -> 25 beats
//    o_data=25 (100/4), o_lane 0..24, o_last only on lane 24, o_vld first at t+1.
//  2 K=3 accumulate: lane n psum=n,n,n, shift=0 -> o_data[n]=3n (lane 24 -> 72).
//  3 Rounding/sign: acc=-6, shift=2 -> -1; acc=6, shift=2 -> 2; acc=5, shift=1 -> 3.
//  4 Saturation: acc=1000, shift=0 -> 127 with PSUM_DRAIN_SAT_EN, -24 (0xE8) without;
//    acc=-1000 -> -128 / 24.
//  5 Back-pressure: i_rdy toggled 1/0 each cycle -> 25 handshakes in 50 cycles, o_data
//    and o_lane held while stalled; vld beat during DRAIN -> o_drop pulse, acc unchanged.
//  6 Protocol/reset: vld&!first in IDLE -> o_drop, no state change; rst at lane 10 of
//    drain -> next cycle o_vld=0, state IDLE, new sequence drains from lane 0.

Source files
------------

// File: rtl/tile_psum_drain_pkg.sv
// Shared constants, state encoding and lane helpers for the tile partial-sum drain stage.
// Build option: define PSUM_DRAIN_SAT_EN to saturate, instead of wrap, the narrowed outputs.
package tile_pkg;

  localparam int DEF_AK_BW  = 20;
  localparam int DEF_LANES  = 25;
  localparam int DEF_ACC_BW = 24;
  localparam int DEF_O_BW   = 8;
  localparam int DEF_SH_BW  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } tile_state_e;

  // Bit offset of lane n inside a flat bus of `width`-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/tile_psum_drain_if.sv
// Beat-side (tile array -> drain) and stream-side (drain -> writer) bundles.
// The beat side carries the per-lane partial sums plus busy/drop status back to the array.
interface tile_psum_if
  import tile_pkg::*;
#(
  parameter int AK_BW = DEF_AK_BW,
  parameter int LANES = DEF_LANES,
  parameter int SH_BW = DEF_SH_BW
);
  logic                     psum_vld;
  logic                     psum_first;
  logic                     psum_last;
  logic [AK_BW*LANES-1:0]   psum;
  logic [SH_BW-1:0]         shift;
  logic                     busy;
  logic                     drop;

  modport master (
    output psum_vld, psum_first, psum_last, psum, shift,
    input  busy, drop
  );

  modport slave (
    input  psum_vld, psum_first, psum_last, psum, shift,
    output busy, drop
  );
endinterface

interface tile_out_if
  import tile_pkg::*;
#(
  parameter int O_BW  = DEF_O_BW,
  parameter int LANES = DEF_LANES
);
  localparam int LANE_W = $clog2(LANES);

  logic                     vld;
  logic                     rdy;
  logic signed [O_BW-1:0]   data;
  logic [LANE_W-1:0]        lane;
  logic                     last;

  modport master (
    output vld, data, lane, last,
    input  rdy
  );

  modport slave (
    input  vld, data, lane, last,
    output rdy
  );
endinterface

// File: rtl/tile_psum_drain_psum_requant.sv
// Combinational requantizer: round-half-up arithmetic right shift, then narrow to O_BW.
// PSUM_DRAIN_SAT_EN selects clamping on the narrow; otherwise the low bits are kept (wraps).
module psum_requant
  import tile_pkg::*;
#(
  parameter int ACC_BW = DEF_ACC_BW,
  parameter int O_BW   = DEF_O_BW,
  parameter int SH_BW  = DEF_SH_BW
) (
  input  logic signed [ACC_BW-1:0] i_acc,
  input  logic        [SH_BW-1:0]  i_sh,
  output logic signed [O_BW-1:0]   o_data
);

  // One extra bit so adding the rounding half can never wrap.
  localparam int V_BW = ACC_BW + 1;

  function automatic logic signed [V_BW-1:0] round_shift(
    input logic signed [ACC_BW-1:0] a,
    input logic        [SH_BW-1:0]  sh
  );
    logic signed [V_BW-1:0] ext;
    logic signed [V_BW-1:0] half;
    ext  = V_BW'(a);
    half = '0;
    if (sh != '0) begin
      half = V_BW'(1) <<< (sh - SH_BW'(1));
    end
    return (ext + half) >>> sh;
  endfunction

`ifdef PSUM_DRAIN_SAT_EN
  localparam logic signed [V_BW-1:0] O_MAX = V_BW'((1 <<< (O_BW - 1)) - 1);
  localparam logic signed [V_BW-1:0] O_MIN = V_BW'(-(1 <<< (O_BW - 1)));

  function automatic logic signed [O_BW-1:0] narrow(input logic signed [V_BW-1:0] v);
    logic signed [V_BW-1:0] c;
    if (v > O_MAX) begin
      c = O_MAX;
    end else if (v < O_MIN) begin
      c = O_MIN;
    end else begin
      c = v;
    end
    return c[O_BW-1:0];
  endfunction
`else
  function automatic logic signed [O_BW-1:0] narrow(input logic signed [V_BW-1:0] v);
    return v[O_BW-1:0];
  endfunction
`endif

  logic signed [V_BW-1:0] v_p0;

  always_comb begin
    v_p0   = round_shift(i_acc, i_sh);
    o_data = narrow(v_p0);
  end

endmodule

// File: rtl/tile_psum_drain.sv
// Accumulates K passes of per-lane partial sums, then drains requantized lanes one per handshake.
// Build option PSUM_DRAIN_SAT_EN (in psum_requant) saturates the narrowed outputs.
module tile_psum_drain
  import tile_pkg::*;
#(
  parameter int AK_BW  = DEF_AK_BW,
  parameter int LANES  = DEF_LANES,
  parameter int ACC_BW = DEF_ACC_BW,
  parameter int O_BW   = DEF_O_BW,
  parameter int SH_BW  = DEF_SH_BW
) (
  input  logic       clk,
  input  logic       rst,
  tile_psum_if.slave psum_s,
  tile_out_if.master out_m
);

  localparam int LANE_W = $clog2(LANES);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ACCUM = ST_ACCUM;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

  logic [1:0]               state_q, state_d;
  logic [LANE_W-1:0]        cnt_q, cnt_d;
  logic [SH_BW-1:0]         shift_q, shift_d;
  logic                     drop_q, drop_d;
  logic signed [ACC_BW-1:0] acc_q [LANES];
  logic signed [ACC_BW-1:0] acc_d [LANES];

  logic signed [AK_BW-1:0]  lane_p0 [LANES];
  logic signed [ACC_BW-1:0] acc_sel_p0;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    assign lane_p0[n] = psum_s.psum[lane_lsb(n, AK_BW) +: AK_BW];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    drop_d  = 1'b0;
    acc_d   = acc_q;

    case (state_q)
      S_IDLE: begin
        if (psum_s.psum_vld) begin
          if (psum_s.psum_first) begin
            for (int n = 0; n < LANES; n++) begin
              acc_d[n] = ACC_BW'(lane_p0[n]);
            end
            if (psum_s.psum_last) begin
              shift_d = psum_s.shift;
              state_d = S_DRAIN;
            end else begin
              state_d = S_ACCUM;
            end
          end else begin
            // A continuation beat with no sequence open has nothing to add to.
            drop_d = 1'b1;
          end
        end
      end

      S_ACCUM: begin
        if (psum_s.psum_vld) begin
          // A new first beat restarts the sequence rather than adding onto stale sums.
          for (int n = 0; n < LANES; n++) begin
            acc_d[n] = psum_s.psum_first ? ACC_BW'(lane_p0[n])
                                         : acc_q[n] + ACC_BW'(lane_p0[n]);
          end
          if (psum_s.psum_last) begin
            shift_d = psum_s.shift;
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        drop_d = psum_s.psum_vld;
        if (out_m.rdy) begin
          if (cnt_q == LANE_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + LANE_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      drop_q  <= 1'b0;
      for (int n = 0; n < LANES; n++) begin
        acc_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      drop_q  <= drop_d;
      acc_q   <= acc_d;
    end
  end

  // Drain mux: only the lane being presented goes through the requantizer.
  assign acc_sel_p0 = acc_q[cnt_q];

  psum_requant #(
    .ACC_BW (ACC_BW),
    .O_BW   (O_BW),
    .SH_BW  (SH_BW)
  ) u_requant (
    .i_acc  (acc_sel_p0),
    .i_sh   (shift_q),
    .o_data (out_m.data)
  );

  assign out_m.vld   = (state_q == S_DRAIN);
  assign out_m.lane  = cnt_q;
  assign out_m.last  = (state_q == S_DRAIN) && (cnt_q == LANE_LAST);
  assign psum_s.busy = (state_q == S_DRAIN);
  assign psum_s.drop = drop_q;

endmodule
